// File: rtl/irrigation_sequencer_pkg.sv
// Shared types and constants for the irrigation phase sequencer.
// Holds the phase codes, the FSM encoding, the BCD widths and the binary-to-BCD helper.
package irrig_pkg;

  localparam logic [1:0] PH_FILL   = 2'b00;
  localparam logic [1:0] PH_DRIP   = 2'b01;
  localparam logic [1:0] PH_SPRINK = 2'b10;
  localparam logic [1:0] PH_CLEAN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_IRRIG = 2'b10,
    ST_CLEAN = 2'b11
  } state_t;

  localparam int BCD_UNITS_W = 4;
  localparam int BCD_TENS_W  = 2;
  localparam int LOAD_W      = 6;
  localparam int T_MIN       = 1;
  localparam int T_MAX       = 39;

  typedef struct packed {
    logic [BCD_TENS_W-1:0]  tens;
    logic [BCD_UNITS_W-1:0] units;
  } bcd_t;

  // Values above 39 never reach this; the sequencer rejects them at elaboration.
  function automatic bcd_t bin_to_bcd(input logic [LOAD_W-1:0] v);
    bcd_t r;
    if (v >= 6'd30) begin
      r.tens  = 2'd3;
      r.units = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      r.tens  = 2'd2;
      r.units = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      r.tens  = 2'd1;
      r.units = 4'(v - 6'd10);
    end else begin
      r.tens  = 2'd0;
      r.units = v[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Operator/sensor inputs and display/valve outputs of the irrigation sequencer.
interface irrigation_sequencer_if;
  import irrig_pkg::*;

  logic                   tick;
  logic                   start;
  logic                   mode;
  logic                   abort;
  logic                   tank_full;
  logic [1:0]             phase;
  logic                   busy;
  logic                   phase_load;
  logic                   done;
  logic [BCD_UNITS_W-1:0] sec_units;
  logic [BCD_TENS_W-1:0]  sec_tens;

  modport master (
    output tick, start, mode, abort, tank_full,
    input  phase, busy, phase_load, done, sec_units, sec_tens
  );

  modport slave (
    input  tick, start, mode, abort, tank_full,
    output phase, busy, phase_load, done, sec_units, sec_tens
  );

endinterface

// File: rtl/irrigation_sequencer_bcd_down_counter.sv
// Shared two-digit BCD countdown: load wins over decrement, units borrow from tens.
module bcd_down_counter
  import irrig_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [LOAD_W-1:0]      load_val,
  input  logic                   dec,
  output logic [BCD_UNITS_W-1:0] units,
  output logic [BCD_TENS_W-1:0]  tens,
  output logic                   is_one
);

  bcd_t count_r;
  bcd_t count_next_s;

  // Next count: fresh load, BCD decrement, or hold.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = bin_to_bcd(load_val);
    end else if (dec) begin
      if (count_r.units == 4'd0) begin
        count_next_s.units = 4'd9;
        count_next_s.tens  = count_r.tens - 2'd1;
      end else begin
        count_next_s.units = count_r.units - 4'd1;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '{tens: 2'd0, units: 4'd0};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign units  = count_r.units;
  assign tens   = count_r.tens;
  assign is_one = (count_r.tens == 2'd0) && (count_r.units == 4'd1);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation phase sequencer: FILL -> drip/sprinkler -> CLEAN, one shared BCD countdown.
// Priority within a cycle is abort > tank_full > tick; a phase entry always reloads the count.
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int FILL_T   = 15,
  parameter int DRIP_T   = 39,
  parameter int SPRINK_T = 25,
  parameter int CLEAN_T  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irrigation_sequencer_if.slave bus
);

  if (FILL_T < T_MIN || FILL_T > T_MAX) begin : g_fill_range
    $error("FILL_T must be within 1..39");
  end
  if (DRIP_T < T_MIN || DRIP_T > T_MAX) begin : g_drip_range
    $error("DRIP_T must be within 1..39");
  end
  if (SPRINK_T < T_MIN || SPRINK_T > T_MAX) begin : g_sprink_range
    $error("SPRINK_T must be within 1..39");
  end
  if (CLEAN_T < T_MIN || CLEAN_T > T_MAX) begin : g_clean_range
    $error("CLEAN_T must be within 1..39");
  end

  localparam logic [LOAD_W-1:0] FILL_V   = LOAD_W'(FILL_T);
  localparam logic [LOAD_W-1:0] DRIP_V   = LOAD_W'(DRIP_T);
  localparam logic [LOAD_W-1:0] SPRINK_V = LOAD_W'(SPRINK_T);
  localparam logic [LOAD_W-1:0] CLEAN_V  = LOAD_W'(CLEAN_T);

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   mode_r;
  logic                   mode_next_s;
  logic                   load_s;
  logic [LOAD_W-1:0]      load_val_s;
  logic [LOAD_W-1:0]      irrig_val_s;
  logic                   dec_s;
  logic                   is_one_s;
  logic                   done_next_s;
  logic [1:0]             phase_next_s;
  logic                   busy_next_s;
  logic                   phase_load_next_s;
  logic [1:0]             phase_r;
  logic                   busy_r;
  logic                   phase_load_r;
  logic                   done_r;
  logic [BCD_UNITS_W-1:0] units_s;
  logic [BCD_TENS_W-1:0]  tens_s;

  assign irrig_val_s = mode_r ? SPRINK_V : DRIP_V;

  // State and latched irrigation mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      mode_r  <= mode_next_s;
    end
  end

  // Next state plus the counter load/decrement commands for this cycle.
  always_comb begin
    state_next_s = state_r;
    mode_next_s  = mode_r;
    load_s       = 1'b0;
    load_val_s   = 6'd0;
    dec_s        = 1'b0;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_FILL;
          mode_next_s  = bus.mode;
          load_s       = 1'b1;
          load_val_s   = FILL_V;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (bus.abort) begin
          state_next_s = ST_CLEAN;
          load_s       = 1'b1;
          load_val_s   = CLEAN_V;
        end else if (bus.tank_full || (bus.tick && is_one_s)) begin
          state_next_s = ST_IRRIG;
          load_s       = 1'b1;
          load_val_s   = irrig_val_s;
        end else if (bus.tick) begin
          dec_s = 1'b1;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_IRRIG: begin
        if (bus.abort || (bus.tick && is_one_s)) begin
          state_next_s = ST_CLEAN;
          load_s       = 1'b1;
          load_val_s   = CLEAN_V;
        end else if (bus.tick) begin
          dec_s = 1'b1;
        end else begin
          state_next_s = ST_IRRIG;
        end
      end
      ST_CLEAN: begin
        if (bus.tick && is_one_s) begin
          state_next_s = ST_IDLE;
          load_s       = 1'b1;
          load_val_s   = 6'd0;
          done_next_s  = 1'b1;
        end else if (bus.tick) begin
          dec_s = 1'b1;
        end else begin
          state_next_s = ST_CLEAN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from where the FSM is heading.
  always_comb begin
    busy_next_s       = (state_next_s != ST_IDLE);
    phase_load_next_s = (state_next_s != state_r) && (state_next_s != ST_IDLE);
    case (state_next_s)
      ST_IDLE:  phase_next_s = PH_FILL;
      ST_FILL:  phase_next_s = PH_FILL;
      ST_IRRIG: phase_next_s = {mode_next_s, ~mode_next_s};
      ST_CLEAN: phase_next_s = PH_CLEAN;
      default:  phase_next_s = PH_FILL;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r      <= 2'b00;
      busy_r       <= 1'b0;
      phase_load_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      phase_r      <= phase_next_s;
      busy_r       <= busy_next_s;
      phase_load_r <= phase_load_next_s;
      done_r       <= done_next_s;
    end
  end

  bcd_down_counter u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .units    (units_s),
    .tens     (tens_s),
    .is_one   (is_one_s)
  );

  assign bus.phase      = phase_r;
  assign bus.busy       = busy_r;
  assign bus.phase_load = phase_load_r;
  assign bus.done       = done_r;
  assign bus.sec_units  = units_s;
  assign bus.sec_tens   = tens_s;

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
Phase sequencer for the irrigation timer. It generates the 2-bit phase code that selects the active per-phase countdown: fill, then drip or sprinkler, then clean. It owns a single shared BCD countdown that shows time remaining in the current phase. This replaces the four parallel per-phase counters and removes the output multiplexing. It sits between the operator inputs (start/abort/mode), the tank-level sensor and the display/valve drivers.

Parameters:
FILL_T, 15, fill duration in ticks; legal range 1..39.
DRIP_T, 39, drip duration in ticks; legal range 1..39.
SPRINK_T, 25, sprinkler duration in ticks; legal range 1..39.
CLEAN_T, 10, clean duration in ticks; legal range 1..39.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle time-base enable, 1 per second, synchronous to clk
start  in  1  level; begins a cycle when sampled high in IDLE
mode  in  1  irrigation type, sampled with start: 0 = drip, 1 = sprinkler
abort  in  1  level; jumps to clean
tank_full  in  1  level sensor; ends fill early
phase  out  2  {ff2,ff1}: 00 fill, 01 drip, 10 sprinkler, 11 clean
busy  out  1  high in any non-IDLE state
phase_load  out  1  one-cycle pulse on the first cycle of each phase
done  out  1  one-cycle pulse when clean completes
sec_units  out  4  BCD units of remaining ticks
sec_tens  out  2  BCD tens of remaining ticks (0..3)

Behaviour:
- Reset: one clock, asynchronous active-low reset. While rst_n=0: state=IDLE, mode_r=0, phase=00, busy=0, phase_load=0, done=0, sec_units=0, sec_tens=0. Reset mid-phase abandons the cycle immediately; there is no clean on reset.
- All outputs are registered.
- States: IDLE, FILL, IRRIG, CLEAN. In IRRIG, phase = {mode_r, ~mode_r}, i.e. 01 for drip, 10 for sprinkler. In IDLE, phase=00 and busy=0.
- IDLE, start=1 at an edge: latch mode into mode_r, load FILL_T, enter FILL. phase_load=1 on that next cycle.
- Countdown: on a tick with count>1, decrement the BCD value. Units borrow from tens; 10 -> 09.
- On a tick with count==1, advance to the next phase:
  - FILL -> IRRIG, loading DRIP_T or SPRINK_T.
  - IRRIG -> CLEAN, loading CLEAN_T.
  - CLEAN -> IDLE, with count=0 and done=1 for one cycle.
- Each phase therefore lasts exactly T ticks, and the display shows T..1.
- tank_full=1 in FILL: advance to IRRIG on the next edge, independent of tick.
- abort=1 in FILL or IRRIG: go to CLEAN, loading CLEAN_T. abort in CLEAN or IDLE: ignored.
- phase_load pulses once per phase entry, including entry via abort or tank_full.
- Simultaneous-event priority: abort > tank_full > tick. One transition per cycle at most.
- start while busy: ignored. mode changes after start: ignored.
- start and abort together in IDLE: start taken.
- A tick in the same cycle as a phase entry: not applied to the newly loaded count.
- Parameters outside 1..39: elaboration error.

Decomposition:
- Package irrig_pkg holds:
  - phase codes PH_FILL=2'b00, PH_DRIP=2'b01, PH_SPRINK=2'b10, PH_CLEAN=2'b11
  - the state encoding
  - the BCD width constants
- Sub-module bcd_down_counter holds the 6-bit BCD register.
  - Inputs: clk, rst_n, load, load_val (binary 1..39, converted to BCD internally), dec.
  - Outputs: units, tens, is_one.

Test Plan:
- Test parameters: FILL_T=3, DRIP_T=12, SPRINK_T=5, CLEAN_T=2.
- Reset mid-FILL with count=2: all outputs 0 asynchronously; after release, IDLE, busy=0.
- start, mode=0, tick every 4 clk: phase 00 shows 3,2,1 -> phase 01 shows 12,11,10,09,..,1 -> phase 11 shows 2,1 -> IDLE. done pulses exactly once. phase_load pulses 3 times.
- start, mode=1: IRRIG phase=10 for exactly 5 ticks, count 5..1. Toggling mode mid-cycle has no effect.
- tank_full=1 two cycles after entering FILL, no tick: phase 01 on the next edge, count=12, phase_load=1.
- abort during IRRIG at count=07, together with a tick: phase=11, count=2 (no decrement), phase_load=1. A further abort in CLEAN leaves count unchanged.
- start held high through a full cycle: exactly one extra cycle starts, on the edge after done. start pulses while busy have no effect.
